// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end for one shared SLL/SRL/SRA shifter
module shift_arbiter #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic [N-1:0]  req0_data,
    input  logic [SW-1:0] req0_shamt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic [N-1:0]  req1_data,
    input  logic [SW-1:0] req1_shamt,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [N-1:0]  resp_data
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic          can_accept;
    logic          grant_any;
    logic          grant;
    logic          accept;
    logic [1:0]    sel_op;
    logic [N-1:0]  sel_data;
    logic [SW-1:0] sel_shamt;
    logic [N-1:0]  sll_res, srl_res, sra_res, shift_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        can_accept = (state == EMPTY) | (resp_valid & resp_ready);
        grant_any  = req0_valid | req1_valid;
        if (req0_valid & req1_valid) grant = ~last_grant;
        else                         grant = req1_valid;
        accept     = req0_ready | req1_ready;
        state_nxt  = state;
        if (accept)                          state_nxt = FULL;
        else if (state == FULL && resp_ready) state_nxt = EMPTY;
    end

    // Readies are masked by rst because the async reset forces EMPTY, which would otherwise look acceptable.
    always_comb begin
        resp_valid = (state == FULL);
        req0_ready = ~rst & can_accept & grant_any & ~grant;
        req1_ready = ~rst & can_accept & grant_any & grant;
    end

    always_comb begin
        sel_op    = grant ? req1_op    : req0_op;
        sel_data  = grant ? req1_data  : req0_data;
        sel_shamt = grant ? req1_shamt : req0_shamt;
        sll_res   = sel_data << sel_shamt;
        srl_res   = sel_data >> sel_shamt;
        sra_res   = $unsigned($signed(sel_data) >>> sel_shamt);
        case (sel_op)
            2'b00:   shift_res = sll_res;
            2'b01:   shift_res = srl_res;
            2'b10:   shift_res = sra_res;
            default: shift_res = sel_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else if (accept) begin
            last_grant <= grant;
            resp_id    <= grant;
            resp_data  <= shift_res;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed and randomized checks of shift_arbiter against an arithmetic reference
module tb_shift_arbiter;
    localparam int N  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]    req0_op, req1_op;
    logic [N-1:0]  req0_data, req1_data;
    logic [SW-1:0] req0_shamt, req1_shamt;
    logic          resp_valid, resp_ready, resp_id;
    logic [N-1:0]  resp_data;

    int passed = 0;
    int total  = 0;

    // Reference state: what the result register should hold and who last won.
    logic          m_valid;
    logic          m_id;
    logic [N-1:0]  m_data;
    logic          m_last;

    shift_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_shift(input logic [1:0] op, input logic [N-1:0] d,
                                               input logic [SW-1:0] s);
        longint unsigned p;
        longint unsigned wide;
        p    = 64'd1 << s;
        wide = {32'd0, d};
        case (op)
            2'd0:    return N'((wide * p) % (64'd1 << N));
            2'd1:    return N'(wide / p);
            2'd2:    return d[N-1] ? ~N'({32'd0, ~d} / p) : N'(wide / p);
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_data  = '0;
        m_last  = 1'b1;
    endtask

    // One cycle: drive, check readies before the edge, clock, check the response after the edge.
    task automatic step(input logic v0, input logic [1:0] o0, input logic [N-1:0] d0, input logic [SW-1:0] s0,
                        input logic v1, input logic [1:0] o1, input logic [N-1:0] d1, input logic [SW-1:0] s1,
                        input logic rr);
        logic can, g, e0, e1;
        req0_valid = v0; req0_op = o0; req0_data = d0; req0_shamt = s0;
        req1_valid = v1; req1_op = o1; req1_data = d1; req1_shamt = s1;
        resp_ready = rr;
        #1;
        can = !m_valid || rr;
        g   = (v0 && v1) ? !m_last : v1;
        e0  = can && (v0 || v1) && !g;
        e1  = can && (v0 || v1) && g;
        chk("req0_ready", N'(req0_ready), N'(e0));
        chk("req1_ready", N'(req1_ready), N'(e1));
        @(posedge clk);
        #1;
        if (e0 || e1) begin
            m_valid = 1'b1;
            m_id    = g;
            m_last  = g;
            m_data  = g ? ref_shift(o1, d1, s1) : ref_shift(o0, d0, s0);
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        chk("resp_valid", N'(resp_valid), N'(m_valid));
        if (m_valid) begin
            chk("resp_id", N'(resp_id), N'(m_id));
            chk("resp_data", resp_data, m_data);
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, '0, rr);
    endtask

    logic [N-1:0] held;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_data = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_data = '0; req1_shamt = '0;
        resp_ready = 1'b0;
        model_reset();
        #12;
        chk("reset_resp_valid", N'(resp_valid), '0);
        chk("reset_resp_id", N'(resp_id), '0);
        chk("reset_resp_data", resp_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requests on req0
        step(1'b1, 2'd2, 32'h8000_0000, 5'd4, 1'b0, 2'd0, '0, '0, 1'b1);
        chk("sra_const", resp_data, 32'hF800_0000);
        step(1'b1, 2'd1, 32'h8000_0000, 5'd4, 1'b0, 2'd0, '0, '0, 1'b1);
        chk("srl_const", resp_data, 32'h0800_0000);

        // Op coverage on req1
        step(1'b0, 2'd0, '0, '0, 1'b1, 2'd0, 32'h0000_0001, 5'd31, 1'b1);
        chk("sll31_const", resp_data, 32'h8000_0000);
        step(1'b0, 2'd0, '0, '0, 1'b1, 2'd2, 32'h7FFF_FFF0, 5'd4, 1'b1);
        chk("sra_pos_const", resp_data, 32'h07FF_FFFF);
        step(1'b0, 2'd0, '0, '0, 1'b1, 2'd3, 32'h1234_5678, 5'd9, 1'b1);
        chk("pass_const", resp_data, 32'h1234_5678);
        step(1'b0, 2'd0, '0, '0, 1'b1, 2'd2, 32'hFFFF_0000, 5'd0, 1'b1);
        chk("sra0_const", resp_data, 32'hFFFF_0000);
        step(1'b0, 2'd0, '0, '0, 1'b1, 2'd2, 32'h8000_0000, 5'd31, 1'b1);
        chk("sra31_const", resp_data, 32'hFFFF_FFFF);
        idle(1'b1);

        // Contention: last winner was req1, so req0 leads and grants alternate
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 32'h0000_0003, 5'(i), 1'b1, 2'd1, 32'hF000_0000, 5'(i), 1'b1);
            chk("alt_id", N'(resp_id), N'(i % 2));
        end
        idle(1'b1);

        // Backpressure: fill from req0, stall three cycles with both pending
        step(1'b1, 2'd0, 32'h0000_00FF, 5'd8, 1'b0, 2'd0, '0, '0, 1'b1);
        held = resp_data;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd1, 32'hAAAA_0000, 5'd1, 1'b1, 2'd2, 32'h8000_0000, 5'd2, 1'b0);
            chk("stall_data", resp_data, held);
        end
        step(1'b1, 2'd1, 32'hAAAA_0000, 5'd1, 1'b1, 2'd2, 32'h8000_0000, 5'd2, 1'b1);
        chk("bp_winner", N'(resp_id), 32'd1);
        chk("bp_data", resp_data, 32'hE000_0000);

        // Drain and load in the same cycle, no bubble
        step(1'b1, 2'd3, 32'hCAFE_F00D, 5'd3, 1'b0, 2'd0, '0, '0, 1'b1);
        chk("b2b_valid", N'(resp_valid), 32'd1);
        chk("b2b_data", resp_data, 32'hCAFE_F00D);

        // Reset while FULL and stalled
        step(1'b1, 2'd0, 32'h1, 5'd1, 1'b0, 2'd0, '0, '0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", N'(resp_valid), '0);
        chk("rst_ready0", N'(req0_ready), '0);
        chk("rst_ready1", N'(req1_ready), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 2'd0, 32'h5, 5'd1, 1'b1, 2'd0, 32'h7, 5'd1, 1'b1);
        chk("post_rst_first", N'(resp_id), '0);

        // Randomized traffic against the reference
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom), $urandom, 5'($urandom),
                 1'($urandom_range(0, 1)), 2'($urandom), $urandom, 5'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
